// File: rtl/arbitro_rr8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// N_REQ/IDX_W are tied to the 3-to-8 decoder width and are not meant to change.
package arbitro_rr8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        LIBRE    = 2'b00,
        ASIGNADO = 2'b01,
        PAUSA    = 2'b10
    } estado_t;

endpackage

// File: rtl/arbitro_rr8_decodificador.sv
// 3-to-8 decoder with enable; its one-hot output is the arbiter's grant bus.
module arbitro_rr8_decodificador
    import arbitro_rr8_pkg::*;
(
    input  logic [IDX_W-1:0] ent,
    output logic [N_REQ-1:0] sal,
    input  logic             ena
);

    always_comb begin
        sal = '0;
        if (ena) sal[ent] = 1'b1;
    end

endmodule

// File: rtl/arbitro_rr8.sv
// 8-way round-robin arbiter: one dead cycle between grants, optional hold timeout.
// idx/ena are registered and drive the decoder that produces the one-hot grant conc.
module arbitro_rr8
    import arbitro_rr8_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] sol,
    input  logic             fin,
    output logic [IDX_W-1:0] idx,
    output logic             ena,
    output logic [N_REQ-1:0] conc,
    output logic             exp
);

    estado_t          estado, estado_nx;
    logic [IDX_W-1:0] ptr, ptr_nx, idx_nx, pick;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic             ena_nx, exp_nx, rel_norm, timeout;

    // First requester found scanning ptr+1, ptr+2, ... modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] cand, res;
        logic             found;
        res   = base;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = base + IDX_W'(k);
            if (!found && req[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign pick     = rr_pick(sol, ptr);
    assign rel_norm = fin || !sol[idx];
    assign timeout  = (MAX_HOLD != 0) && (cnt == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        estado_nx = estado;
        idx_nx    = idx;
        ena_nx    = ena;
        exp_nx    = 1'b0;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        case (estado)
            LIBRE, PAUSA: begin
                if (|sol) begin
                    idx_nx    = pick;
                    ena_nx    = 1'b1;
                    cnt_nx    = '0;
                    estado_nx = ASIGNADO;
                end else begin
                    ena_nx    = 1'b0;
                    estado_nx = LIBRE;
                end
            end
            ASIGNADO: begin
                // A normal release in the timeout cycle takes priority, so exp stays low.
                if (rel_norm || timeout) begin
                    ena_nx    = 1'b0;
                    ptr_nx    = idx;
                    exp_nx    = !rel_norm;
                    estado_nx = PAUSA;
                end else begin
                    cnt_nx = cnt + HOLD_W'(1);
                end
            end
            default: begin
                ena_nx    = 1'b0;
                estado_nx = LIBRE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= LIBRE;
            idx    <= '0;
            ena    <= 1'b0;
            exp    <= 1'b0;
            ptr    <= IDX_W'(N_REQ - 1);
            cnt    <= '0;
        end else begin
            estado <= estado_nx;
            idx    <= idx_nx;
            ena    <= ena_nx;
            exp    <= exp_nx;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
        end
    end

    arbitro_rr8_decodificador u_dec (
        .ent (idx),
        .sal (conc),
        .ena (ena)
    );

endmodule

// File: tb/tb_arbitro_rr8.sv
// Directed bench for arbitro_rr8: reset, single grant, rotation, timeout, collision, async reset.
module tb_arbitro_rr8;
    import arbitro_rr8_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] sol;
    logic             fin;
    logic [IDX_W-1:0] idx;
    logic             ena;
    logic [N_REQ-1:0] conc;
    logic             exp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arbitro_rr8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sol   (sol),
        .fin   (fin),
        .idx   (idx),
        .ena   (ena),
        .conc  (conc),
        .exp   (exp)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sol = 8'hFF; fin = 1'b0;
        step(); step();
        n_tests++; if (ena !== 1'b0)    begin n_fail++; $display("FAIL reset_ena got %b exp 0", ena); end
        n_tests++; if (conc !== 8'h00)  begin n_fail++; $display("FAIL reset_conc got %h exp 00", conc); end
        n_tests++; if (idx !== 3'd0)    begin n_fail++; $display("FAIL reset_idx got %0d exp 0", idx); end
        n_tests++; if (exp !== 1'b0)    begin n_fail++; $display("FAIL reset_exp got %b exp 0", exp); end
        rst_n = 1'b1;
        step();
        n_tests++; if ({ena, idx, conc} !== {1'b1, 3'd0, 8'h01})
            begin n_fail++; $display("FAIL reset_first_grant got ena=%b idx=%0d conc=%h exp 1/0/01", ena, idx, conc); end
        sol = 8'h00;
        step();
        n_tests++; if ({ena, conc} !== {1'b0, 8'h00})
            begin n_fail++; $display("FAIL reset_release got ena=%b conc=%h exp 0/00", ena, conc); end
        step();
    endtask

    task automatic test_single();
        sol = 8'h04;
        step();
        n_tests++; if ({ena, idx, conc} !== {1'b1, 3'd2, 8'h04})
            begin n_fail++; $display("FAIL single_grant got ena=%b idx=%0d conc=%h exp 1/2/04", ena, idx, conc); end
        sol = 8'h00;
        step();
        n_tests++; if ({ena, conc, idx} !== {1'b0, 8'h00, 3'd2})
            begin n_fail++; $display("FAIL single_pausa got ena=%b conc=%h idx=%0d exp 0/00/2", ena, conc, idx); end
        fin = 1'b1;
        step();
        fin = 1'b0;
        step();
        n_tests++; if ({ena, conc} !== {1'b0, 8'h00})
            begin n_fail++; $display("FAIL single_idle_fin got ena=%b conc=%h exp 0/00", ena, conc); end
    endtask

    task automatic test_rotation();
        logic [IDX_W-1:0] want;
        logic [N_REQ-1:0] want_oh;
        pulse_reset();
        sol = 8'hFF;
        step();
        for (int i = 0; i < 9; i++) begin
            want    = IDX_W'(i % 8);
            want_oh = N_REQ'(1) << want;
            n_tests++; if ({ena, idx, conc} !== {1'b1, want, want_oh})
                begin n_fail++; $display("FAIL rot_grant%0d got ena=%b idx=%0d conc=%h exp 1/%0d/%h", i, ena, idx, conc, want, want_oh); end
            step();
            fin = 1'b1;
            step();
            fin = 1'b0;
            n_tests++; if ({ena, conc} !== {1'b0, 8'h00})
                begin n_fail++; $display("FAIL rot_gap%0d got ena=%b conc=%h exp 0/00", i, ena, conc); end
            step();
        end
        sol = 8'h00;
        step(); step();
    endtask

    task automatic test_timeout();
        int hi;
        pulse_reset();
        sol = 8'h01;
        step();
        hi = 0;
        while (ena === 1'b1 && hi < 30) begin
            hi++;
            step();
        end
        n_tests++; if (hi !== 15) begin n_fail++; $display("FAIL timeout_len got %0d exp 15", hi); end
        n_tests++; if ({ena, exp} !== {1'b0, 1'b1})
            begin n_fail++; $display("FAIL timeout_exp got ena=%b exp=%b exp 0/1", ena, exp); end
        step();
        n_tests++; if ({ena, idx, exp} !== {1'b1, 3'd0, 1'b0})
            begin n_fail++; $display("FAIL timeout_regrant got ena=%b idx=%0d exp=%b exp 1/0/0", ena, idx, exp); end
    endtask

    // Continues from the regrant of idx 0 (cnt=0 in this cycle).
    task automatic test_collision();
        sol = 8'h03;
        for (int i = 0; i < 14; i++) step();
        n_tests++; if ({ena, idx} !== {1'b1, 3'd0})
            begin n_fail++; $display("FAIL coll_held got ena=%b idx=%0d exp 1/0", ena, idx); end
        fin = 1'b1;
        step();
        fin = 1'b0;
        n_tests++; if ({ena, exp} !== {1'b0, 1'b0})
            begin n_fail++; $display("FAIL coll_release got ena=%b exp=%b exp 0/0", ena, exp); end
        step();
        n_tests++; if ({ena, idx, conc} !== {1'b1, 3'd1, 8'h02})
            begin n_fail++; $display("FAIL coll_next got ena=%b idx=%0d conc=%h exp 1/1/02", ena, idx, conc); end
        sol = 8'h00;
        step(); step();
    endtask

    task automatic test_async_reset();
        pulse_reset();
        sol = 8'h20;
        step();
        n_tests++; if (conc !== 8'h20) begin n_fail++; $display("FAIL areset_pre got conc=%h exp 20", conc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({ena, conc} !== {1'b0, 8'h00})
            begin n_fail++; $display("FAIL areset_clear got ena=%b conc=%h exp 0/00", ena, conc); end
        sol = 8'h21;
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if ({ena, idx, conc} !== {1'b1, 3'd0, 8'h01})
            begin n_fail++; $display("FAIL areset_regrant got ena=%b idx=%0d conc=%h exp 1/0/01", ena, idx, conc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
